// File: rtl/cc_miss_request_unit_if.sv
// Miss-request, miss-address-FIFO and AXI read-channel signals of the
// cache-controller miss request unit. The unit side uses the master modport;
// the tag-compare stage, FIFO and memory side use the slave modport.
interface cc_miss_request_unit_if;
    // Miss request from tag compare
    logic        miss_req_valid;
    logic [31:0] miss_req_addr;
    logic        miss_req_ready;
    // Miss address FIFO push side
    logic        miss_addr_fifo_full;
    logic        miss_addr_fifo_wren;
    logic [31:0] miss_addr_fifo_wdata;
    // AXI read address channel
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic [3:0]  mem_arlen;
    logic [2:0]  mem_arsize;
    logic [1:0]  mem_arburst;
    // AXI read data channel (monitored only)
    logic        mem_rvalid;
    logic        mem_rready;
    logic        mem_rlast;

    modport master (
        input  miss_req_valid, miss_req_addr,
        output miss_req_ready,
        input  miss_addr_fifo_full,
        output miss_addr_fifo_wren, miss_addr_fifo_wdata,
        output mem_arvalid,
        input  mem_arready,
        output mem_araddr, mem_arlen, mem_arsize, mem_arburst,
        input  mem_rvalid, mem_rready, mem_rlast
    );

    modport slave (
        output miss_req_valid, miss_req_addr,
        input  miss_req_ready,
        output miss_addr_fifo_full,
        input  miss_addr_fifo_wren, miss_addr_fifo_wdata,
        input  mem_arvalid,
        output mem_arready,
        input  mem_araddr, mem_arlen, mem_arsize, mem_arburst,
        output mem_rvalid, mem_rready, mem_rlast
    );
endinterface

// File: rtl/cc_miss_request_unit.sv
// Cache-controller miss request unit: accepts one miss at a time, pushes the
// line address into the miss address FIFO in the accept cycle, then issues a
// critical-word-first 8 x 64-bit WRAP read burst. Counts line fills whose R
// burst has not yet delivered rlast and stops accepting at MAX_OUTSTANDING.
module cc_miss_request_unit #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cc_miss_request_unit_if.master bus,
    output logic [2:0]            outstanding,
    output logic                  err
);
    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, ARREQ} state_t;

    state_t      state_q, state_d;
    logic [31:0] araddr_q;
    logic [2:0]  count_q, count_d;
    logic        err_q, err_d;
    logic        ready;
    logic        accept;
    logic        rlast_hs;
    logic [31:0] line_addr;

    // Critical word first: the burst starts at the 64-bit word that missed.
    assign line_addr = {bus.miss_req_addr[31:3], 3'b000};
    assign rlast_hs  = bus.mem_rvalid && bus.mem_rready && bus.mem_rlast;

    // Request FSM: accept in IDLE, hold AR in ARREQ until the slave takes it.
    always_comb begin
        // NOTE: every output of this block is defaulted first so that no path
        // leaves a signal unassigned and infers a latch.
        state_d = state_q;
        ready   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                ready  = !bus.miss_addr_fifo_full && (count_q < MAX_OUT);
                accept = bus.miss_req_valid && ready;
                if (accept) state_d = ARREQ;
            end
            ARREQ: begin
                if (bus.mem_arready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outstanding-fill bookkeeping; an rlast with nothing outstanding is an error.
    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        if (rlast_hs && (count_q == 3'd0)) err_d = 1'b1;
        if (accept && !rlast_hs) begin
            count_d = count_q + 3'd1;
        end else if (!accept && rlast_hs && (count_q != 3'd0)) begin
            count_d = count_q - 3'd1;
        end
    end

    // State, AR address, counter and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q  <= IDLE;
            araddr_q <= 32'd0;
            count_q  <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            if (accept) araddr_q <= line_addr;
        end
    end

    // Push happens in the accept cycle, so it always precedes the AR.
    assign bus.miss_req_ready       = ready;
    assign bus.miss_addr_fifo_wren  = accept;
    assign bus.miss_addr_fifo_wdata = line_addr;

    assign bus.mem_arvalid = (state_q == ARREQ);
    assign bus.mem_araddr  = araddr_q;
    assign bus.mem_arlen   = 4'd7;
    assign bus.mem_arsize  = 3'b011;
    assign bus.mem_arburst = 2'b10;

    assign outstanding = count_q;
    assign err         = err_q;
endmodule

// File: tb/tb_cc_miss_request_unit.sv
// Self-checking bench for cc_miss_request_unit: directed scenarios followed by
// random traffic, all compared cycle by cycle against a transaction-level model
// (pending AR address, outstanding fill count, sticky error).
module tb_cc_miss_request_unit;
    localparam int MAX_OUT = 2;

    logic       clk;
    logic       rst_n;
    logic [2:0] outstanding;
    logic       err;

    cc_miss_request_unit_if bus ();

    cc_miss_request_unit #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.master),
        .outstanding (outstanding),
        .err         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_push   = 0;

    // Reference model: one AR may be pending; fills counted as plain integers.
    bit          m_pend;
    logic [31:0] m_addr;
    int          m_cnt;
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = 1'b0;
        m_addr = 32'd0;
        m_cnt  = 0;
        m_err  = 1'b0;
    endtask

    // One clock cycle: inputs are already driven; check at the falling edge,
    // advance the model, then return just after the next rising edge.
    task automatic cycle();
        bit exp_ready, acc, rl;
        @(negedge clk);
        exp_ready = !m_pend && !bus.miss_addr_fifo_full && (m_cnt < MAX_OUT);
        acc       = bus.miss_req_valid && exp_ready;
        rl        = bus.mem_rvalid && bus.mem_rready && bus.mem_rlast;
        check("ready", bus.miss_req_ready, exp_ready);
        check("wren", bus.miss_addr_fifo_wren, acc);
        if (acc) check("wdata", bus.miss_addr_fifo_wdata, bus.miss_req_addr & ~32'h7);
        check("arvalid", bus.mem_arvalid, m_pend);
        if (m_pend) check("araddr", bus.mem_araddr, m_addr);
        check("outstanding", outstanding, m_cnt);
        check("err", err, m_err);
        check("ar_const", {bus.mem_arlen, bus.mem_arsize, bus.mem_arburst}, {4'd7, 3'b011, 2'b10});
        if (bus.miss_addr_fifo_wren) n_push++;
        // Model update for the coming edge.
        if (rl && m_cnt == 0) m_err = 1'b1;
        if (acc && !rl) m_cnt++;
        else if (!acc && rl && m_cnt > 0) m_cnt--;
        if (acc) begin
            m_pend = 1'b1;
            m_addr = bus.miss_req_addr & ~32'h7;
        end else if (m_pend && bus.mem_arready) begin
            m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input bit v);
        bus.mem_rvalid = v;
        bus.mem_rready = v;
        bus.mem_rlast  = v;
    endtask

    initial begin
        rst_n                   = 1'b0;
        bus.miss_req_valid      = 1'b0;
        bus.miss_req_addr       = 32'd0;
        bus.miss_addr_fifo_full = 1'b0;
        bus.mem_arready         = 1'b0;
        set_r(1'b0);
        model_reset();

        // Reset state, including constant AR attributes.
        #3;
        check("rst_arvalid", bus.mem_arvalid, 1'b0);
        check("rst_araddr", bus.mem_araddr, 32'd0);
        check("rst_outstanding", outstanding, 3'd0);
        check("rst_err", err, 1'b0);
        check("rst_wren", bus.miss_addr_fifo_wren, 1'b0);
        check("rst_const", {bus.mem_arlen, bus.mem_arsize, bus.mem_arburst}, {4'd7, 3'b011, 2'b10});
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single miss, AR taken in its first cycle.
        bus.mem_arready    = 1'b1;
        bus.miss_req_valid = 1'b1;
        bus.miss_req_addr  = 32'h0001_2358;
        cycle();
        bus.miss_req_valid = 1'b0;
        check("t1_arvalid", bus.mem_arvalid, 1'b1);
        check("t1_araddr", bus.mem_araddr, 32'h0001_2358);
        check("t1_arlen", bus.mem_arlen, 4'd7);
        check("t1_arburst", bus.mem_arburst, 2'b10);
        cycle();
        check("t1_arvalid_drop", bus.mem_arvalid, 1'b0);
        check("t1_outstanding", outstanding, 3'd1);
        set_r(1'b1);
        cycle();
        set_r(1'b0);

        // 2: AR backpressure for 5 cycles, unaligned address.
        n_push             = 0;
        bus.mem_arready    = 1'b0;
        bus.miss_req_valid = 1'b1;
        bus.miss_req_addr  = 32'h8000_1237;
        cycle();
        bus.miss_req_valid = 1'b0;
        repeat (5) cycle();
        check("t2_araddr_held", bus.mem_araddr, 32'h8000_1230);
        bus.mem_arready = 1'b1;
        cycle();
        check("t2_push_count", n_push, 1);
        set_r(1'b1);
        cycle();
        set_r(1'b0);

        // 3: outstanding limit with three back-to-back misses.
        bus.miss_req_valid = 1'b1;
        bus.miss_req_addr  = 32'h0000_1000;
        cycle();
        cycle();
        bus.miss_req_addr = 32'h0000_2008;
        cycle();
        cycle();
        bus.miss_req_addr = 32'h0000_3010;
        check("t3_ready_blocked", bus.miss_req_ready, 1'b0);
        cycle();
        set_r(1'b1);
        cycle();
        set_r(1'b0);
        check("t3_outstanding_dec", outstanding, 3'd1);
        check("t3_ready_rises", bus.miss_req_ready, 1'b1);
        cycle();
        bus.miss_req_valid = 1'b0;
        cycle();
        set_r(1'b1);
        cycle();
        cycle();
        set_r(1'b0);

        // 4: accept with simultaneous rlast, then rlast with nothing outstanding.
        bus.miss_req_valid = 1'b1;
        bus.miss_req_addr  = 32'h1234_5678;
        cycle();
        bus.miss_req_valid = 1'b0;
        cycle();
        bus.miss_req_valid = 1'b1;
        bus.miss_req_addr  = 32'h2345_6788;
        set_r(1'b1);
        cycle();
        bus.miss_req_valid = 1'b0;
        set_r(1'b0);
        check("t4_same_cycle", outstanding, 3'd1);
        cycle();
        set_r(1'b1);
        cycle();
        cycle();
        set_r(1'b0);
        check("t4_err_set", err, 1'b1);
        check("t4_no_wrap", outstanding, 3'd0);
        repeat (2) cycle();

        // 5: FIFO full blocks acceptance; push happens the cycle full drops.
        bus.miss_addr_fifo_full = 1'b1;
        bus.miss_req_valid      = 1'b1;
        bus.miss_req_addr       = 32'hCAFE_0040;
        repeat (4) cycle();
        bus.miss_addr_fifo_full = 1'b0;
        #1;
        check("t5_ready", bus.miss_req_ready, 1'b1);
        check("t5_wren", bus.miss_addr_fifo_wren, 1'b1);
        cycle();
        bus.miss_req_valid = 1'b0;
        cycle();

        // 6: asynchronous reset while AR is pending.
        bus.mem_arready    = 1'b0;
        bus.miss_req_valid = 1'b1;
        bus.miss_req_addr  = 32'hDEAD_BEE8;
        cycle();
        bus.miss_req_valid = 1'b0;
        check("t6_arvalid_pre", bus.mem_arvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_arvalid_async", bus.mem_arvalid, 1'b0);
        check("t6_outstanding_async", outstanding, 3'd0);
        check("t6_err_async", err, 1'b0);
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_arready    = 1'b1;
        bus.miss_req_valid = 1'b1;
        bus.miss_req_addr  = 32'h0BAD_F00D;
        cycle();
        bus.miss_req_valid = 1'b0;
        cycle();
        set_r(1'b1);
        cycle();
        set_r(1'b0);

        // Random traffic; rlast only offered while fills are outstanding.
        for (int i = 0; i < 1500; i++) begin
            bus.miss_req_valid      = ($urandom_range(0, 2) != 0);
            bus.miss_req_addr       = $urandom;
            bus.miss_addr_fifo_full = ($urandom_range(0, 3) == 0);
            bus.mem_arready         = ($urandom_range(0, 2) != 0);
            bus.mem_rvalid          = ($urandom_range(0, 1) == 1);
            bus.mem_rready          = ($urandom_range(0, 1) == 1);
            bus.mem_rlast           = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cc_miss_request_unit.md
Name: cc_miss_request_unit

Overview:
- Sits upstream of the cache-controller data fill unit.
- Accepts one cache-miss request at a time from the tag-compare stage and pushes the miss address into the miss address FIFO, which the fill unit later pops.
- Issues the matching AXI read-address burst: 8 beats x 64 bit, critical-word-first, WRAP.
- Tracks outstanding line fills so that FIFO entries and R bursts never exceed MAX_OUTSTANDING.

Parameters:
MAX_OUTSTANDING, 2, maximum number of miss requests accepted whose R burst (rlast) has not yet completed; legal range 1..7.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
miss_req_valid_i  input  1  miss request valid from tag compare
miss_req_addr_i  input  32  miss byte address
miss_req_ready_o  output  1  request accepted when valid&ready
miss_addr_fifo_full_i  input  1  miss address FIFO full
miss_addr_fifo_wren_o  output  1  FIFO push strobe
miss_addr_fifo_wdata_o  output  32  FIFO push data
mem_arvalid_o  output  1  AXI AR valid
mem_arready_i  input  1  AXI AR ready
mem_araddr_o  output  32  AXI AR address
mem_arlen_o  output  4  burst length-1, constant 4'd7
mem_arsize_o  output  3  constant 3'b011 (8 B)
mem_arburst_o  output  2  constant 2'b10 (WRAP)
mem_rvalid_i  input  1  AXI R valid (monitored)
mem_rready_i  input  1  AXI R ready (monitored)
mem_rlast_i  input  1  AXI R last (monitored)
outstanding_o  output  3  current outstanding count
err_o  output  1  sticky: rlast handshake seen with outstanding==0

Behaviour:
- Reset (rst_n low, async): state=IDLE; mem_arvalid_o=0; mem_araddr_o=0; outstanding_o=0; err_o=0; miss_addr_fifo_wren_o=0. Reset mid-burst drops arvalid immediately and loses the pending request. No recovery is attempted.
- States: IDLE and ARREQ.
- IDLE:
  - miss_req_ready_o = !miss_addr_fifo_full_i && (outstanding < MAX_OUTSTANDING). This is combinational and does not depend on miss_req_valid_i.
  - Accept = valid&ready. In the accept cycle:
    - miss_addr_fifo_wren_o=1 (combinational, same cycle), with miss_addr_fifo_wdata_o = {miss_req_addr_i[31:3],3'b000}.
    - Register araddr = {addr[31:3],3'b000} (critical word first).
    - Next state is ARREQ.
  - The outstanding increment is registered and takes effect in the next cycle.
- ARREQ:
  - mem_arvalid_o=1 starting the cycle after accept; latency from accept to arvalid is exactly 1 cycle.
  - mem_araddr_o is held stable until mem_arready_i=1.
  - miss_req_ready_o=0 in this state.
  - On arvalid&arready: next state is IDLE, arvalid=0 next cycle, and a new request can be accepted that cycle +1.
  - If arready is already high in the first ARREQ cycle, AR completes in 1 cycle, so the minimum request spacing is 2 cycles.
- Outstanding counter:
  - Increments on accept; decrements on mem_rvalid_i&mem_rready_i&mem_rlast_i.
  - Accept and rlast in the same cycle leave the count unchanged.
  - Decrement at 0 does not wrap: the count stays 0 and err_o is set (sticky until reset).
  - Increment beyond MAX_OUTSTANDING is impossible because ready gates it.
- FIFO full: ready is held low; no push and no AR are issued. Full asserting while in ARREQ does not affect the AR already in flight, because its push already happened.
- The FIFO push precedes the AR by ≥1 cycle, so the fill unit always finds the address before the first R beat.
- Constant outputs (arlen/arsize/arburst) are driven at all times, including reset.

Test Plan:
1. Single miss: valid=1, addr=0x0001_2358, FIFO empty, arready=1 → same cycle: wren=1, wdata=0x0001_2358, ready=1. Next cycle: arvalid=1, araddr=0x0001_2358, arlen=7, arburst=2. Following cycle: arvalid=0, outstanding=1.
2. AR backpressure: arready held 0 for 5 cycles → arvalid and araddr stable for 6 cycles, ready=0 throughout, exactly one FIFO push.
3. Outstanding limit: with MAX_OUTSTANDING=2, three back-to-back misses and no R traffic → third request sees ready=0. An rlast handshake follows → outstanding 2→1, and the third request is accepted the same cycle ready rises.
4. Simultaneous events: accept and rlast handshake in the same cycle with outstanding=1 → outstanding stays 1. An rlast with outstanding=0 → outstanding stays 0 and err_o=1 until reset.
5. FIFO full: full_i=1 with valid=1 for 4 cycles → ready=0 and wren=0. When full_i drops, the push happens that cycle.
6. Async reset in ARREQ: assert rst_n=0 mid-cycle while arvalid=1 → arvalid=0 and outstanding=0 without waiting for a clock edge. After release, a new miss is processed normally.
